chn_burst_arbiter: RTL and testbench

- Parametrised N-channel acquisition buffer. It sits between the per-channel ADC data formatters and the USB external FIFO.
- Each channel writes into its own internal FIFO. A round-robin burst reader drains one channel at a time in fixed-length bursts.
- Each burst is optionally preceded by a channel-tagged header word.
- Adds three behaviours: flush of partial bursts, downstream backpressure, and sticky per-channel overflow flags.

---
 rtl/chn_burst_arbiter.sv | 280 ++++++++++++++++++++++++++++
 tb/tb_chn_burst_arbiter.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/chn_burst_arbiter.sv
// chn_burst_arbiter: N-channel acquisition buffer.
// Each channel fills its own FIFO. A round-robin burst reader drains one
// channel at a time. Each burst can be preceded by a channel-tagged header.
// The block supports flush of partial bursts, downstream backpressure and
// sticky per-channel overflow flags.
module chn_burst_arbiter #(
  parameter int NUM_CHN   = 2,
  parameter int DATA_W    = 16,
  parameter int FIFO_AW   = 11,
  parameter int BURST_LEN = 1024,
  parameter int HEADER_EN = 1,
  parameter int CHN_W     = 4
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      rst_all_fifo,
  input  logic                      flush,
  input  logic [NUM_CHN*DATA_W-1:0] chn_data,
  input  logic [NUM_CHN-1:0]        chn_en,
  input  logic                      out_full,
  output logic [DATA_W-1:0]         out_data,
  output logic                      out_valid,
  output logic                      busy,
  output logic [CHN_W-1:0]          cur_chn,
  output logic [NUM_CHN-1:0]        ovf
);

  localparam int SEL_W = (NUM_CHN > 1) ? $clog2(NUM_CHN) : 1;
  localparam int DEPTH = 2 ** FIFO_AW;
  localparam logic [FIFO_AW:0]   FULL_C    = (FIFO_AW + 1)'(DEPTH);
  localparam logic [FIFO_AW:0]   BURST_C   = (FIFO_AW + 1)'(BURST_LEN);
  localparam logic [FIFO_AW:0]   CNT_ONE_C = (FIFO_AW + 1)'(1);
  localparam logic [FIFO_AW-1:0] PTR_ONE_C = (FIFO_AW)'(1);
  localparam logic [SEL_W-1:0]   SEL_ONE_C = (SEL_W)'(1);
  localparam logic [SEL_W-1:0]   SEL_MAX_C = (SEL_W)'(NUM_CHN - 1);
  localparam logic [7:0]         HDR_TAG_C = 8'hA5;

  typedef enum logic [1:0] {
    SCAN   = 2'd0,
    HEADER = 2'd1,
    READ   = 2'd2,
    DRAIN  = 2'd3
  } state_t;

  // Per-channel FIFO storage and bookkeeping
  logic [DATA_W-1:0]  mem_r    [NUM_CHN][DEPTH];
  logic [FIFO_AW:0]   cnt_r    [NUM_CHN];
  logic [FIFO_AW-1:0] wr_ptr_r [NUM_CHN];
  logic [FIFO_AW-1:0] rd_ptr_r [NUM_CHN];
  logic [NUM_CHN-1:0] wr_ok_s;
  logic [NUM_CHN-1:0] rd_ok_s;
  logic [NUM_CHN-1:0] elig_s;
  logic [NUM_CHN-1:0] ovf_r;

  // Burst control
  state_t             state_r;
  state_t             state_next_s;
  logic [SEL_W-1:0]   sel_r;
  logic [SEL_W-1:0]   rr_ptr_r;
  logic [SEL_W-1:0]   pick_s;
  logic [SEL_W-1:0]   idx_s;
  logic               found_s;
  logic [FIFO_AW:0]   len_s;
  logic [FIFO_AW:0]   rem_r;
  logic               rd_en_s;
  logic               load_s;
  logic               hdr_emit_s;
  logic               drain_s;
  logic [DATA_W-1:0]  hdr_s;

  // Registered outputs
  logic [DATA_W-1:0]  out_data_r;
  logic               out_valid_r;
  logic               busy_r;
  logic [CHN_W-1:0]   cur_chn_r;

  // Per-channel write acceptance, read strobe and burst eligibility
  always_comb begin
    wr_ok_s = '0;
    rd_ok_s = '0;
    elig_s  = '0;
    for (int i = 0; i < NUM_CHN; i++) begin
      wr_ok_s[i] = chn_en[i] && (cnt_r[i] != FULL_C);
      rd_ok_s[i] = rd_en_s && (sel_r == (SEL_W)'(i));
      elig_s[i]  = (cnt_r[i] >= BURST_C) || (flush && (cnt_r[i] != '0));
    end
  end

  // Round-robin search for the first eligible channel starting at rr_ptr
  always_comb begin
    found_s = 1'b0;
    pick_s  = '0;
    idx_s   = '0;
    for (int k = 0; k < NUM_CHN; k++) begin
      idx_s = (SEL_W)'((int'(rr_ptr_r) + k) % NUM_CHN);
      if (!found_s && elig_s[idx_s]) begin
        found_s = 1'b1;
        pick_s  = idx_s;
      end else begin
        found_s = found_s;
      end
    end
  end

  // Burst length is the smaller of the fill level and the nominal burst size
  always_comb begin
    if (cnt_r[pick_s] >= BURST_C) begin
      len_s = BURST_C;
    end else begin
      len_s = cnt_r[pick_s];
    end
  end

  // Header word: tag in the top byte, selected channel zero-extended below
  always_comb begin
    hdr_s                  = '0;
    hdr_s[DATA_W-1 -: 8]   = HDR_TAG_C;
    hdr_s[SEL_W-1:0]       = sel_r;
  end

  // FIFO counters, pointers and sticky overflow flags
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_CHN; i++) begin
        cnt_r[i]    <= '0;
        wr_ptr_r[i] <= '0;
        rd_ptr_r[i] <= '0;
      end
      ovf_r <= '0;
    end else if (rst_all_fifo) begin
      for (int i = 0; i < NUM_CHN; i++) begin
        cnt_r[i]    <= '0;
        wr_ptr_r[i] <= '0;
        rd_ptr_r[i] <= '0;
      end
      ovf_r <= '0;
    end else begin
      for (int i = 0; i < NUM_CHN; i++) begin
        if (wr_ok_s[i] && !rd_ok_s[i]) begin
          cnt_r[i] <= cnt_r[i] + CNT_ONE_C;
        end else if (!wr_ok_s[i] && rd_ok_s[i]) begin
          cnt_r[i] <= cnt_r[i] - CNT_ONE_C;
        end else begin
          cnt_r[i] <= cnt_r[i];
        end
        if (wr_ok_s[i]) begin
          wr_ptr_r[i] <= wr_ptr_r[i] + PTR_ONE_C;
        end else begin
          wr_ptr_r[i] <= wr_ptr_r[i];
        end
        if (rd_ok_s[i]) begin
          rd_ptr_r[i] <= rd_ptr_r[i] + PTR_ONE_C;
        end else begin
          rd_ptr_r[i] <= rd_ptr_r[i];
        end
        if (chn_en[i] && !wr_ok_s[i]) begin
          ovf_r[i] <= 1'b1;
        end else begin
          ovf_r[i] <= ovf_r[i];
        end
      end
    end
  end

  // FIFO storage writes; contents need no reset because counts gate reads
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_CHN; i++) begin
      if (wr_ok_s[i] && !rst_all_fifo) begin
        mem_r[i][wr_ptr_r[i]] <= chn_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= SCAN;
    end else if (rst_all_fifo) begin
      state_r <= SCAN;
    end else begin
      state_r <= state_next_s;
    end
  end

  // FSM next-state and per-cycle control strobes
  always_comb begin
    state_next_s = state_r;
    rd_en_s      = 1'b0;
    load_s       = 1'b0;
    hdr_emit_s   = 1'b0;
    drain_s      = 1'b0;
    case (state_r)
      SCAN: begin
        if (found_s) begin
          load_s       = 1'b1;
          state_next_s = (HEADER_EN != 0) ? HEADER : READ;
        end else begin
          state_next_s = SCAN;
        end
      end
      HEADER: begin
        if (!out_full) begin
          hdr_emit_s   = 1'b1;
          state_next_s = READ;
        end else begin
          state_next_s = HEADER;
        end
      end
      READ: begin
        if (rem_r == '0) begin
          state_next_s = DRAIN;
        end else if (!out_full) begin
          rd_en_s      = 1'b1;
          state_next_s = (rem_r == CNT_ONE_C) ? DRAIN : READ;
        end else begin
          state_next_s = READ;
        end
      end
      DRAIN: begin
        drain_s      = 1'b1;
        state_next_s = SCAN;
      end
      default: begin
        state_next_s = SCAN;
      end
    endcase
  end

  // Burst datapath: selection latch, remaining count, round-robin pointer, outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sel_r       <= '0;
      rr_ptr_r    <= '0;
      rem_r       <= '0;
      cur_chn_r   <= '0;
      out_valid_r <= 1'b0;
      out_data_r  <= '0;
      busy_r      <= 1'b0;
    end else if (rst_all_fifo) begin
      sel_r       <= '0;
      rr_ptr_r    <= '0;
      rem_r       <= '0;
      cur_chn_r   <= '0;
      out_valid_r <= 1'b0;
      out_data_r  <= '0;
      busy_r      <= 1'b0;
    end else begin
      if (load_s) begin
        sel_r     <= pick_s;
        cur_chn_r <= (CHN_W)'(pick_s);
        rem_r     <= len_s;
      end else if (rd_en_s) begin
        rem_r     <= rem_r - CNT_ONE_C;
      end else begin
        rem_r     <= rem_r;
      end
      if (drain_s) begin
        rr_ptr_r <= (sel_r == SEL_MAX_C) ? '0 : (sel_r + SEL_ONE_C);
      end else begin
        rr_ptr_r <= rr_ptr_r;
      end
      out_valid_r <= rd_en_s || hdr_emit_s;
      if (rd_en_s) begin
        out_data_r <= mem_r[sel_r][rd_ptr_r[sel_r]];
      end else if (hdr_emit_s) begin
        out_data_r <= hdr_s;
      end else begin
        out_data_r <= out_data_r;
      end
      busy_r <= (state_next_s != SCAN);
    end
  end

  assign out_data  = out_data_r;
  assign out_valid = out_valid_r;
  assign busy      = busy_r;
  assign cur_chn   = cur_chn_r;
  assign ovf       = ovf_r;

endmodule

// File: tb/tb_chn_burst_arbiter.sv
// Scoreboard bench for chn_burst_arbiter (2 channels, depth 8, burst 4, headers on).
module tb_chn_burst_arbiter;

  logic        clk;
  logic        reset_n;
  logic        rst_all_fifo;
  logic        flush;
  logic [31:0] chn_data;
  logic [1:0]  chn_en;
  logic        out_full;
  logic [15:0] out_data;
  logic        out_valid;
  logic        busy;
  logic [3:0]  cur_chn;
  logic [1:0]  ovf;

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_q[$];

  chn_burst_arbiter #(
    .NUM_CHN(2), .DATA_W(16), .FIFO_AW(3), .BURST_LEN(4), .HEADER_EN(1), .CHN_W(4)
  ) dut (
    .clk(clk), .reset_n(reset_n), .rst_all_fifo(rst_all_fifo), .flush(flush),
    .chn_data(chn_data), .chn_en(chn_en), .out_full(out_full),
    .out_data(out_data), .out_valid(out_valid), .busy(busy),
    .cur_chn(cur_chn), .ovf(ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: every emitted word must match the head of the expected queue
  always @(negedge clk) begin
    logic [15:0] e;
    if (reset_n && out_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_word act=%h exp=none", out_data);
      end else begin
        e = exp_q.pop_front();
        if (out_data !== e) begin
          errors++;
          $display("FAIL word act=%h exp=%h", out_data, e);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  // Called at posedge+1; each word is written on the following posedge
  task automatic wr(input logic [1:0] mask, input int n, input logic [15:0] b0, input logic [15:0] b1);
    for (int k = 0; k < n; k++) begin
      chn_en   = mask;
      chn_data = {b1 + 16'(k), b0 + 16'(k)};
      @(posedge clk); #1;
    end
    chn_en   = 2'b00;
    chn_data = 32'h0;
  endtask

  task automatic push_burst(input logic [15:0] hdr, input logic [15:0] base, input int n);
    exp_q.push_back(hdr);
    for (int k = 0; k < n; k++) exp_q.push_back(base + 16'(k));
  endtask

  task automatic wait_idle(input string nm);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (n >= 300) begin
      errors++;
      $display("FAIL %s_timeout act=%0d_pending exp=0", nm, exp_q.size());
    end
    repeat (5) begin @(posedge clk); #1; end
  endtask

  task automatic wait_word(input string nm, input logic [15:0] w);
    int n;
    n = 0;
    while (!(out_valid && out_data == w) && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (n >= 100) begin
      errors++;
      $display("FAIL %s_timeout act=none exp=%h", nm, w);
    end
  endtask

  initial begin
    int cnt;
    reset_n = 1'b0; rst_all_fifo = 1'b0; flush = 1'b0;
    chn_data = 32'h0; chn_en = 2'b00; out_full = 1'b0;
    #12 reset_n = 1'b1;
    @(posedge clk); #1;

    // Reset state
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_cur_chn", 32'(cur_chn), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);

    // Fairness: 8 words on both channels -> ch0, ch1, ch0, ch1
    push_burst(16'hA500, 16'h1000, 4);
    push_burst(16'hA501, 16'h2000, 4);
    push_burst(16'hA500, 16'h1004, 4);
    push_burst(16'hA501, 16'h2004, 4);
    wr(2'b11, 8, 16'h1000, 16'h2000);
    wait_idle("fair");
    chk("fair_cur_chn", 32'(cur_chn), 32'd1);
    chk("fair_ovf", 32'(ovf), 32'd0);

    // Backpressure: hold out_full for 5 cycles right after the first data word
    push_burst(16'hA500, 16'h3000, 4);
    wr(2'b01, 4, 16'h3000, 16'h0);
    wait_word("bp_first", 16'h3000);
    out_full = 1'b1;
    cnt = 0;
    repeat (5) begin
      @(posedge clk); #1;
      if (out_valid) cnt++;
    end
    checks++;
    if (cnt > 1) begin
      errors++;
      $display("FAIL bp_words_while_full act=%0d exp<=1", cnt);
    end
    out_full = 1'b0;
    wait_idle("bp");

    // Flush: 3 words on ch1 only, then flush releases a partial burst
    push_burst(16'hA501, 16'h4000, 3);
    wr(2'b10, 3, 16'h0, 16'h4000);
    repeat (4) begin @(posedge clk); #1; end
    chk("flush_no_early_burst", 32'(busy), 32'd0);
    flush = 1'b1;
    wait_idle("flush");
    chk("flush_busy", 32'(busy), 32'd0);
    chk("flush_cur_chn", 32'(cur_chn), 32'd1);
    flush = 1'b0;

    // Overflow: 9 writes to ch0 with reads blocked by out_full
    out_full = 1'b1;
    wr(2'b01, 9, 16'h5000, 16'h0);
    chk("ovf_set", 32'(ovf), 32'd1);
    push_burst(16'hA500, 16'h5000, 4);
    push_burst(16'hA500, 16'h5004, 4);
    out_full = 1'b0;
    wait_idle("ovf");
    chk("ovf_sticky", 32'(ovf), 32'd1);
    rst_all_fifo = 1'b1;
    @(posedge clk); #1;
    rst_all_fifo = 1'b0;
    chk("ovf_cleared", 32'(ovf), 32'd0);

    // Mid-burst clear: complete ch0 burst (rr_ptr -> 1), abort ch1 burst
    push_burst(16'hA500, 16'h6000, 4);
    wr(2'b01, 4, 16'h6000, 16'h0);
    wait_idle("pre_clr");
    push_burst(16'hA501, 16'h7000, 4);
    wr(2'b10, 4, 16'h0, 16'h7000);
    wait_word("clr_first", 16'h7000);
    rst_all_fifo = 1'b1;
    @(posedge clk); #1;
    rst_all_fifo = 1'b0;
    exp_q.delete();
    chk("clr_out_valid", 32'(out_valid), 32'd0);
    chk("clr_busy", 32'(busy), 32'd0);
    chk("clr_cur_chn", 32'(cur_chn), 32'd0);
    chk("clr_ovf", 32'(ovf), 32'd0);
    repeat (3) begin @(posedge clk); #1; end
    chk("clr_quiet", 32'(out_valid), 32'd0);
    // rr_ptr back at 0: simultaneous fill must serve ch0 before ch1
    push_burst(16'hA500, 16'h8000, 4);
    push_burst(16'hA501, 16'h9000, 4);
    wr(2'b11, 4, 16'h8000, 16'h9000);
    wait_idle("post_clr");

    // Async reset between clock edges mid-burst
    push_burst(16'hA500, 16'h6100, 4);
    wr(2'b01, 4, 16'h6100, 16'h0);
    wait_word("ar_first", 16'h6100);
    #5 reset_n = 1'b0;
    #1;
    exp_q.delete();
    chk("ar_out_valid", 32'(out_valid), 32'd0);
    chk("ar_out_data", 32'(out_data), 32'd0);
    chk("ar_busy", 32'(busy), 32'd0);
    chk("ar_cur_chn", 32'(cur_chn), 32'd0);
    #1 reset_n = 1'b1;
    cnt = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (out_valid || busy) cnt++;
    end
    chk("ar_silent", 32'(cnt), 32'd0);
    push_burst(16'hA501, 16'h6200, 4);
    wr(2'b10, 4, 16'h0, 16'h6200);
    wait_idle("ar_new");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
